// File: rtl/elastic_pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg_pkg
// Shared constants and types for the elastic pipeline register.
//   INST_NOP        - instruction-payload bubble (addi x0,x0,0)
//   PIPE_DEPTH_MAX  - largest supported slot count
//   occ_op_e        - occupancy counter update selector
//   occ_width()     - occupancy port width for a given depth (at least 1 bit)
// -----------------------------------------------------------------------------
package elastic_pipe_reg_pkg;

    localparam logic [31:0] INST_NOP       = 32'h0000_0013;
    localparam int          PIPE_DEPTH_MAX = 16;

    typedef enum logic [1:0] {
        OCC_HOLD,
        OCC_INC,
        OCC_DEC,
        OCC_CLR
    } occ_op_e;

    // $clog2(2*DEPTH+1) collapses to 0 for DEPTH=0; keep the port legal.
    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(2 * depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/elastic_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg_if
// valid/ready/data handshake bundle for one side of an elastic stage.
//   valid - producer offers a beat
//   ready - consumer accepts this cycle
//   data  - WIDTH-bit opaque payload
// Modports: master (producer), slave (consumer).
// -----------------------------------------------------------------------------
interface elastic_pipe_reg_if #(
    parameter int WIDTH = 32
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/elastic_pipe_slot.sv
// -----------------------------------------------------------------------------
// elastic_pipe_slot
// One register slot of the elastic pipe. Empty slots hold BUBBLE_VALUE.
// Build option: ELASTIC_PIPE_SKID_EN adds a one-entry skid buffer so that
// up_ready is registered (no combinational dn_ready -> up_ready path).
// Ports:
//   clock, reset_n (async active-low), flush (sync squash)
//   up_valid/up_ready/up_data - upstream handshake
//   dn_valid/dn_ready/dn_data - downstream handshake (main entry)
// -----------------------------------------------------------------------------
module elastic_pipe_slot #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             up_xfer;
    logic             dn_xfer;

    assign dn_valid = main_valid;
    assign dn_data  = main_data;
    assign up_xfer  = up_valid & up_ready;
    assign dn_xfer  = main_valid & dn_ready;

`ifdef ELASTIC_PIPE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign up_ready = ~skid_valid;

    // up_xfer implies skid empty, so a refill from skid never races upstream.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE_VALUE;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE_VALUE;
        end else if (dn_xfer) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_data  <= BUBBLE_VALUE;
            end else if (up_xfer) begin
                main_data  <= up_data;
            end else begin
                main_valid <= 1'b0;
                main_data  <= BUBBLE_VALUE;
            end
        end else if (up_xfer) begin
            if (main_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= up_data;
            end else begin
                main_valid <= 1'b1;
                main_data  <= up_data;
            end
        end
    end
`else
    assign up_ready = ~main_valid | dn_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
        end else if (up_xfer) begin
            main_valid <= 1'b1;
            main_data  <= up_data;
        end else if (dn_xfer) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
        end
    end
`endif

endmodule

// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
// Handshaked stage register: WIDTH-bit payload through DEPTH slots, strict
// FIFO order, BUBBLE_VALUE in every empty slot and on dn.data when idle.
// DEPTH=0 is a combinational pass-through with no state.
// Build option: ELASTIC_PIPE_SKID_EN (per-slot skid entry, capacity 2*DEPTH);
// ignored when DEPTH=0.
// Ports:
//   clock      - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   flush      - synchronous squash of all held entries
//   up         - upstream handshake (slave): valid/ready/data
//   dn         - downstream handshake (master): valid/ready/data
//   occupancy  - number of valid entries, including skid entries
// -----------------------------------------------------------------------------
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    elastic_pipe_reg_if.slave             up,
    elastic_pipe_reg_if.master            dn,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    if (DEPTH == 0) begin : g_pass
        assign dn.valid  = up.valid & ~flush;
        assign dn.data   = up.valid ? up.data : BUBBLE_VALUE;
        assign up.ready  = dn.ready & ~flush & reset_n;
        assign occupancy = '0;
    end else begin : g_chain
        logic [DEPTH:0]            v;
        logic [DEPTH:0]            r;
        logic [DEPTH:0][WIDTH-1:0] d;
        logic                      in_xfer;
        logic                      out_xfer;
        occ_op_e                   occ_op;

        assign v[0]     = up.valid;
        assign d[0]     = up.data;
        assign r[DEPTH] = dn.ready;

        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            elastic_pipe_slot #(
                .WIDTH        (WIDTH),
                .BUBBLE_VALUE (BUBBLE_VALUE)
            ) u_slot (
                .clock    (clock),
                .reset_n  (reset_n),
                .flush    (flush),
                .up_valid (v[i]),
                .up_ready (r[i]),
                .up_data  (d[i]),
                .dn_valid (v[i+1]),
                .dn_ready (r[i+1]),
                .dn_data  (d[i+1])
            );
        end

        // Head slot may accept internally during flush, but flush wins there;
        // gating here keeps the upstream from counting a dropped beat.
        assign up.ready = r[0] & ~flush & reset_n;
        assign dn.valid = v[DEPTH];
        assign dn.data  = d[DEPTH];

        assign in_xfer  = up.valid & up.ready;
        assign out_xfer = v[DEPTH] & dn.ready;

        always_comb begin
            occ_op = OCC_HOLD;
            if (flush) begin
                occ_op = OCC_CLR;
            end else if (in_xfer && !out_xfer) begin
                occ_op = OCC_INC;
            end else if (!in_xfer && out_xfer) begin
                occ_op = OCC_DEC;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                occupancy <= '0;
            end else begin
                case (occ_op)
                    OCC_INC: occupancy <= occupancy + OCC_W'(1);
                    OCC_DEC: occupancy <= occupancy - OCC_W'(1);
                    OCC_CLR: occupancy <= '0;
                    default: occupancy <= occupancy;
                endcase
            end
        end
    end

endmodule
